// File: rtl/alu_cc_fsm_mc_pkg.sv
// alu_cc_pkg: shared state encodings and condition-code constants
package alu_cc_pkg;
    typedef enum logic [3:0] {
        S_PC   = 4'h1,
        S_EXEC = 4'h2,
        S_BR   = 4'h4
    } state_t;
    localparam int CC_N = 2;
    localparam int CC_Z = 1;
    localparam int CC_P = 0;
    localparam logic [2:0] CC_RST = 3'b000;
endpackage

// File: rtl/alu_cc_fsm_mc_if.sv
// alu_cc_fsm_mc_if: decoder/ALU inputs and PC-control outputs of the CC FSM
interface alu_cc_fsm_mc_if #(
    parameter int NUM_CTX = 2,
    parameter int CNT_W = 8,
    localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
);
    logic [CTX_W-1:0] ctx_sel_in;
    logic n_dec_in, z_dec_in, p_dec_in;
    logic n_alu_in, z_alu_in, p_alu_in;
    logic we_reg_in;
    logic br_in;
    logic stall_in;
    logic pc_latch_out;
    logic pc_ctl_0_out;
    logic [3:0] state_out;
    logic [2:0] cc_out;
    logic cc_err_out;
    logic [CNT_W-1:0] br_count_out;
    modport master (
        output ctx_sel_in, n_dec_in, z_dec_in, p_dec_in, n_alu_in, z_alu_in, p_alu_in,
        output we_reg_in, br_in, stall_in,
        input pc_latch_out, pc_ctl_0_out, state_out, cc_out, cc_err_out, br_count_out
    );
    modport slave (
        input ctx_sel_in, n_dec_in, z_dec_in, p_dec_in, n_alu_in, z_alu_in, p_alu_in,
        input we_reg_in, br_in, stall_in,
        output pc_latch_out, pc_ctl_0_out, state_out, cc_out, cc_err_out, br_count_out
    );
endinterface

// File: rtl/alu_cc_fsm_mc_cc_regfile.sv
// cc_regfile: per-context NZP registers, one-hot-checked write, async read
module cc_regfile
    import alu_cc_pkg::*;
#(
    parameter int NUM_CTX = 2,
    localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [CTX_W-1:0] wsel,
    input  logic [2:0]       wdata,
    input  logic [CTX_W-1:0] rsel,
    output logic [2:0]       rdata,
    output logic             wr_bad
);
    logic [2:0] regs [NUM_CTX];
    assign wr_bad = we & ~$onehot(wdata);
    assign rdata = (int'(rsel) < NUM_CTX) ? regs[rsel] : CC_RST;
    // only a clean one-hot flag set to an existing context is stored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTX; i++) regs[i] <= CC_RST;
        end else if (we && $onehot(wdata) && int'(wsel) < NUM_CTX) begin
            regs[wsel] <= wdata;
        end
    end
endmodule

// File: rtl/alu_cc_fsm_mc.sv
// alu_cc_fsm_mc: multi-context CC and branch-resolution FSM driving PC controls
module alu_cc_fsm_mc
    import alu_cc_pkg::*;
#(
    parameter int NUM_CTX = 2,
    parameter int CNT_W = 8
) (
    input logic         clka,
    input logic         reset_in,
    alu_cc_fsm_mc_if.slave bus
);
    state_t state, nxt;
    logic [2:0] mask, flags, cc;
    logic ctx_ok, eval, taken, wr_bad, pc_latch, pc_ctl, err;
    logic [CNT_W-1:0] cnt;
    assign ctx_ok = int'(bus.ctx_sel_in) < NUM_CTX;
    assign eval = (state == S_EXEC) && !bus.stall_in;
    // branch test reads the CC value held before any same-cycle write
    always_comb begin
        mask = '0;
        flags = '0;
        mask[CC_N] = bus.n_dec_in;
        mask[CC_Z] = bus.z_dec_in;
        mask[CC_P] = bus.p_dec_in;
        flags[CC_N] = bus.n_alu_in;
        flags[CC_Z] = bus.z_alu_in;
        flags[CC_P] = bus.p_alu_in;
        taken = bus.br_in && ctx_ok && |(mask & cc);
        nxt = (state == S_EXEC) ? (taken ? S_BR : S_PC) : S_EXEC;
    end
    cc_regfile #(.NUM_CTX(NUM_CTX)) u_cc (
        .clk(clka),
        .rst(reset_in),
        .we(eval && bus.we_reg_in && ctx_ok),
        .wsel(bus.ctx_sel_in),
        .wdata(flags),
        .rsel(bus.ctx_sel_in),
        .rdata(cc),
        .wr_bad(wr_bad)
    );
    // state sequencing with registered PC controls, sticky error and saturating count
    always_ff @(posedge clka) begin
        if (reset_in) begin
            state <= S_PC;
            pc_latch <= 1'b1;
            pc_ctl <= 1'b0;
            err <= 1'b0;
            cnt <= '0;
        end else if (!bus.stall_in) begin
            state <= nxt;
            pc_latch <= nxt != S_EXEC;
            pc_ctl <= nxt == S_BR;
            if (eval && (wr_bad || (!ctx_ok && (bus.we_reg_in || bus.br_in)))) err <= 1'b1;
            if (eval && taken && cnt != '1) cnt <= cnt + 1'b1;
        end
    end
    assign bus.state_out = state;
    assign bus.pc_latch_out = pc_latch;
    assign bus.pc_ctl_0_out = pc_ctl;
    assign bus.cc_out = cc;
    assign bus.cc_err_out = err;
    assign bus.br_count_out = cnt;
endmodule

// File: tb/tb_alu_cc_fsm_mc.sv
// tb_alu_cc_fsm_mc: directed vectors with a queued scoreboard for alu_cc_fsm_mc
module tb_alu_cc_fsm_mc;
    typedef struct packed {
        logic [3:0] st;
        logic lat;
        logic ctl;
        logic [2:0] cc;
        logic err;
        logic [1:0] cnt;
    } obs_t;
    logic clka = 1'b0;
    logic reset_in = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    obs_t exp_q[$];
    string name_q[$];
    alu_cc_fsm_mc_if #(.NUM_CTX(2), .CNT_W(2)) bus ();
    alu_cc_fsm_mc #(.NUM_CTX(2), .CNT_W(2)) dut (.clka(clka), .reset_in(reset_in), .bus(bus));
    always #5 clka = ~clka;
    task automatic v(input string nm, input logic r, input logic s, input logic c,
                     input logic [2:0] m, input logic [2:0] f, input logic w, input logic b,
                     input logic [3:0] es, input logic [2:0] ecc, input logic ee, input logic [1:0] en);
        obs_t e;
        reset_in = r;
        bus.stall_in = s;
        bus.ctx_sel_in = c;
        {bus.n_dec_in, bus.z_dec_in, bus.p_dec_in} = m;
        {bus.n_alu_in, bus.z_alu_in, bus.p_alu_in} = f;
        bus.we_reg_in = w;
        bus.br_in = b;
        e = '{st: es, lat: es != 4'h2, ctl: es == 4'h4, cc: ecc, err: ee, cnt: en};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clka);
        #1;
    endtask
    // monitor: every cycle with a queued expectation is compared mid-cycle
    always @(negedge clka) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a = '{st: bus.state_out, lat: bus.pc_latch_out, ctl: bus.pc_ctl_0_out,
                  cc: bus.cc_out, err: bus.cc_err_out, cnt: bus.br_count_out};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got st=%h lat=%b ctl=%b cc=%b err=%b cnt=%0d, want st=%h lat=%b ctl=%b cc=%b err=%b cnt=%0d",
                         nm, a.st, a.lat, a.ctl, a.cc, a.err, a.cnt, e.st, e.lat, e.ctl, e.cc, e.err, e.cnt);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        bus.stall_in = 1'b0;
        bus.ctx_sel_in = 1'b0;
        {bus.n_dec_in, bus.z_dec_in, bus.p_dec_in} = 3'b000;
        {bus.n_alu_in, bus.z_alu_in, bus.p_alu_in} = 3'b000;
        bus.we_reg_in = 1'b0;
        bus.br_in = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        //  name          rst stl ctx mask    flags   we br  state cc     err cnt
        v("rst_hold",     1, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b000, 0, 2'd0);
        v("rst_rel",      0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b000, 0, 2'd0);
        v("exec_nowe",    0, 0, 0, 3'b000, 3'b100, 0, 0, 4'h2, 3'b000, 0, 2'd0);
        v("pc_ignore",    0, 0, 0, 3'b000, 3'b100, 1, 0, 4'h1, 3'b000, 0, 2'd0);
        v("wr_n",         0, 0, 0, 3'b000, 3'b100, 1, 0, 4'h2, 3'b000, 0, 2'd0);
        v("see_n",        0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b100, 0, 2'd0);
        v("wr_z",         0, 0, 0, 3'b000, 3'b010, 1, 0, 4'h2, 3'b100, 0, 2'd0);
        v("see_z",        0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b010, 0, 2'd0);
        v("wr_p",         0, 0, 0, 3'b000, 3'b001, 1, 0, 4'h2, 3'b010, 0, 2'd0);
        v("see_p",        0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b001, 0, 2'd0);
        v("br_p",         0, 0, 0, 3'b001, 3'b000, 0, 1, 4'h2, 3'b001, 0, 2'd0);
        v("br_p_in_br",   0, 0, 0, 3'b111, 3'b100, 1, 1, 4'h4, 3'b001, 0, 2'd1);
        v("wr_n2",        0, 0, 0, 3'b000, 3'b100, 1, 0, 4'h2, 3'b001, 0, 2'd1);
        v("see_n2",       0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b100, 0, 2'd1);
        v("br_n",         0, 0, 0, 3'b100, 3'b000, 0, 1, 4'h2, 3'b100, 0, 2'd1);
        v("br_n_in_br",   0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h4, 3'b100, 0, 2'd2);
        v("wr_z2",        0, 0, 0, 3'b000, 3'b010, 1, 0, 4'h2, 3'b100, 0, 2'd2);
        v("see_z2",       0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b010, 0, 2'd2);
        v("br_z",         0, 0, 0, 3'b010, 3'b000, 0, 1, 4'h2, 3'b010, 0, 2'd2);
        v("br_z_in_br",   0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h4, 3'b010, 0, 2'd3);
        v("nt_nobr",      0, 0, 0, 3'b010, 3'b000, 0, 0, 4'h2, 3'b010, 0, 2'd3);
        v("nt_nobr_pc",   0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b010, 0, 2'd3);
        v("wr_n3",        0, 0, 0, 3'b000, 3'b100, 1, 0, 4'h2, 3'b010, 0, 2'd3);
        v("see_n3",       0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b100, 0, 2'd3);
        v("nt_mask",      0, 0, 0, 3'b011, 3'b000, 0, 1, 4'h2, 3'b100, 0, 2'd3);
        v("nt_mask_pc",   0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b100, 0, 2'd3);
        v("nt_zero",      0, 0, 1, 3'b111, 3'b000, 0, 1, 4'h2, 3'b000, 0, 2'd3);
        v("nt_zero_pc",   0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b100, 0, 2'd3);
        v("wr_ctx1",      0, 0, 1, 3'b000, 3'b001, 1, 0, 4'h2, 3'b000, 0, 2'd3);
        v("rd_ctx1",      0, 0, 1, 3'b000, 3'b000, 0, 0, 4'h1, 3'b001, 0, 2'd3);
        v("rd_ctx0",      0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h2, 3'b100, 0, 2'd3);
        v("rd_ctx0_pc",   0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b100, 0, 2'd3);
        v("same_cyc",     0, 0, 0, 3'b100, 3'b001, 1, 1, 4'h2, 3'b100, 0, 2'd3);
        v("same_cyc_br",  0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h4, 3'b001, 0, 2'd3);
        v("err_wr",       0, 0, 0, 3'b000, 3'b110, 1, 0, 4'h2, 3'b001, 0, 2'd3);
        v("err_see",      0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b001, 1, 2'd3);
        v("stall1",       0, 1, 0, 3'b001, 3'b100, 1, 1, 4'h2, 3'b001, 1, 2'd3);
        v("stall2",       0, 1, 0, 3'b001, 3'b100, 1, 1, 4'h2, 3'b001, 1, 2'd3);
        v("stall3",       0, 1, 0, 3'b001, 3'b100, 1, 1, 4'h2, 3'b001, 1, 2'd3);
        v("unstall",      0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h2, 3'b001, 1, 2'd3);
        v("unstall_pc",   0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b001, 1, 2'd3);
        v("sat",          0, 0, 0, 3'b001, 3'b000, 0, 1, 4'h2, 3'b001, 1, 2'd3);
        v("sat_in_br",    0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h4, 3'b001, 1, 2'd3);
        v("rst_mid",      1, 0, 0, 3'b001, 3'b000, 0, 1, 4'h2, 3'b001, 1, 2'd3);
        v("post_rst",     0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h1, 3'b000, 0, 2'd0);
        v("post_rst_ex",  0, 0, 0, 3'b000, 3'b000, 0, 0, 4'h2, 3'b000, 0, 2'd0);
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clka);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
